// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared forwarding selects, register constants and scoreboard entry type
package pipeline_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam int SB_REG_W = 5;
    localparam int SB_LAT_W = 3;

    localparam logic [SB_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] rd;
        logic [SB_LAT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one scoreboard entry: load, countdown, self-clear and destination compare
module sb_entry #(
    parameter int REG_W   = 5,
    parameter int LAT_W   = 3,
    parameter int NUM_CMP = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [REG_W-1:0]         load_rd,
    input  logic [LAT_W-1:0]         load_cnt,
    input  logic [NUM_CMP*REG_W-1:0] cmp_rd,
    output logic                     valid,
    output logic [NUM_CMP-1:0]       match
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic [LAT_W-1:0] cnt;
    } entry_t;

    entry_t q;

    // Load is only requested for an invalid entry, so it never races the countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q.valid <= 1'b1;
            q.rd    <= load_rd;
            q.cnt   <= load_cnt;
        end else if (q.valid) begin
            q.cnt <= q.cnt - LAT_W'(1);
            if (q.cnt == LAT_W'(1))
                q.valid <= 1'b0;
        end
    end

    assign valid = q.valid;

    for (genvar c = 0; c < NUM_CMP; c++) begin : g_cmp
        assign match[c] = q.valid && (q.rd == cmp_rd[c*REG_W +: REG_W]);
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// rtl/fwd_hazard_scoreboard.sv - EX operand bypass selects plus multi-cycle producer scoreboard stall
module fwd_hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 4,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_regwrite,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [NUM_SRC*REG_W-1:0] id_ex_rs,
    input  logic [REG_W-1:0]         ex_mem_rd,
    input  logic                     ex_mem_regwrite,
    input  logic [REG_W-1:0]         mem_wb_rd,
    input  logic                     mem_wb_regwrite,
    output logic [NUM_SRC*2-1:0]     forward,
    output logic                     stall,
    output logic                     sb_full,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int NUM_CMP = NUM_SRC + 1;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [REG_W-1:0] rs;
        assign rs = id_ex_rs[i*REG_W +: REG_W];
        assign forward[i*2 +: 2] =
            (ex_mem_regwrite && ex_mem_rd != REG_ZERO && ex_mem_rd == rs) ? FWD_EXMEM :
            (mem_wb_regwrite && mem_wb_rd != REG_ZERO && mem_wb_rd == rs) ? FWD_MEMWB :
                                                                            FWD_IDEX;
    end

    logic [DEPTH-1:0]   valid_vec;
    logic [DEPTH-1:0]   load_vec;
    logic [NUM_CMP-1:0] match_vec [DEPTH];
    logic [NUM_CMP-1:0] any_match;
    logic               alloc_req;
    logic               alloc_go;
    logic               raw;
    logic               waw;
    logic               found;

    // Slots 0..NUM_SRC-1 compare the ID sources, the last slot compares the issuing rd.
    for (genvar j = 0; j < DEPTH; j++) begin : g_entry
        sb_entry #(
            .REG_W   (REG_W),
            .LAT_W   (LAT_W),
            .NUM_CMP (NUM_CMP)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (load_vec[j]),
            .load_rd  (issue_rd),
            .load_cnt (issue_lat),
            .cmp_rd   ({issue_rd, id_rs}),
            .valid    (valid_vec[j]),
            .match    (match_vec[j])
        );
    end

    assign sb_full   = &valid_vec;
    assign alloc_req = issue_regwrite && issue_rd != REG_ZERO && issue_lat != '0;

    always_comb begin
        any_match = '0;
        for (int j = 0; j < DEPTH; j++)
            any_match = any_match | match_vec[j];
    end

    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            raw = raw | (id_rs_used[i] && id_rs[i*REG_W +: REG_W] != REG_ZERO && any_match[i]);
    end

    assign waw      = issue_regwrite && issue_rd != REG_ZERO && any_match[NUM_SRC];
    assign stall    = issue_valid && (raw || waw || (sb_full && alloc_req));
    assign alloc_go = issue_valid && !stall && alloc_req;

    // Pre-edge valid bits pick the slot, so an entry freeing this cycle is not reused yet.
    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (!valid_vec[j] && !found) begin
                load_vec[j] = alloc_go;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb/tb_fwd_hazard_scoreboard.sv - directed self-checking bench for fwd_hazard_scoreboard
module tb_fwd_hazard_scoreboard;

    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 4;
    localparam int LAT_W   = 3;
    localparam int CNT_W   = 4;

    logic                     clk;
    logic                     rst;
    logic                     issue_valid;
    logic                     issue_regwrite;
    logic [REG_W-1:0]         issue_rd;
    logic [LAT_W-1:0]         issue_lat;
    logic [NUM_SRC*REG_W-1:0] id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [NUM_SRC*REG_W-1:0] id_ex_rs;
    logic [REG_W-1:0]         ex_mem_rd;
    logic                     ex_mem_regwrite;
    logic [REG_W-1:0]         mem_wb_rd;
    logic                     mem_wb_regwrite;
    logic [NUM_SRC*2-1:0]     forward;
    logic                     stall;
    logic                     sb_full;
    logic [CNT_W-1:0]         stall_count;

    int n_tests;
    int n_fail;
    int n;

    fwd_hazard_scoreboard #(
        .REG_W   (REG_W),
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH),
        .LAT_W   (LAT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_regwrite  (issue_regwrite),
        .issue_rd        (issue_rd),
        .issue_lat       (issue_lat),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .id_ex_rs        (id_ex_rs),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .forward         (forward),
        .stall           (stall),
        .sb_full         (sb_full),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic set_issue(input logic v, input logic rw, input logic [REG_W-1:0] rd,
                             input logic [LAT_W-1:0] lat);
        issue_valid    = v;
        issue_regwrite = rw;
        issue_rd       = rd;
        issue_lat      = lat;
    endtask

    task automatic count_stalls(output int cycles);
        cycles = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (!stall) break;
            cycles++;
            @(posedge clk);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        set_issue(1'b0, 1'b0, '0, '0);
        id_rs = '0; id_rs_used = '0; id_ex_rs = '0;
        ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
        mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_full", 32'(sb_full), 32'd0);
        chk("reset_count", 32'(stall_count), 32'd0);
        chk("reset_fwd", 32'(forward), 32'd0);

        id_ex_rs = {5'd0, 5'd5};
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
        mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
        #1 chk("fwd_exmem_prio", 32'(forward), 32'b0010);
        ex_mem_rd = 5'd0;
        #1 chk("fwd_memwb", 32'(forward), 32'b0001);
        mem_wb_rd = 5'd0; id_ex_rs = '0;
        #1 chk("fwd_x0", 32'(forward), 32'b0000);
        id_ex_rs = {5'd3, 5'd5}; ex_mem_rd = 5'd3; mem_wb_rd = 5'd5;
        #1 chk("fwd_mixed", 32'(forward), 32'b1001);
        ex_mem_regwrite = 1'b0;
        #1 chk("fwd_exmem_nowrite", 32'(forward), 32'b0001);
        id_ex_rs = '0; ex_mem_rd = '0; mem_wb_rd = '0;
        mem_wb_regwrite = 1'b0;
        tick();
        rst = 1'b0;

        // load-use
        set_issue(1'b1, 1'b1, 5'd7, 3'd1);
        #1 chk("lu_accept", 32'(stall), 32'd0);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
        #1 chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_count", 32'(stall_count), 32'd1);
        tick();
        set_issue(1'b0, 1'b0, '0, '0);
        id_rs = '0; id_rs_used = '0;
        pulse_reset();

        // divider
        set_issue(1'b1, 1'b1, 5'd9, 3'd5);
        #1 chk("div_accept", 32'(stall), 32'd0);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b00;
        #1 chk("div_unused", 32'(stall), 32'd0);
        id_rs_used = 2'b01;
        count_stalls(n);
        chk("div_stall_cycles", 32'(n), 32'd5);
        chk("div_count", 32'(stall_count), 32'd5);
        tick();
        set_issue(1'b0, 1'b0, '0, '0);
        id_rs = '0; id_rs_used = '0;
        pulse_reset();

        // structural and WAW
        for (int r = 1; r <= 4; r++) begin
            set_issue(1'b1, 1'b1, REG_W'(r), 3'd7);
            tick();
        end
        set_issue(1'b0, 1'b0, '0, '0);
        #1 chk("st_full", 32'(sb_full), 32'd1);
        set_issue(1'b1, 1'b1, 5'd2, 3'd0);
        #1 chk("st_waw", 32'(stall), 32'd1);
        set_issue(1'b1, 1'b1, 5'd6, 3'd0);
        #1 chk("st_full_alu", 32'(stall), 32'd0);
        set_issue(1'b1, 1'b1, 5'd0, 3'd3);
        #1 chk("st_full_x0", 32'(stall), 32'd0);
        set_issue(1'b1, 1'b1, 5'd5, 3'd3);
        count_stalls(n);
        chk("st_stall_cycles", 32'(n), 32'd4);
        chk("st_count", 32'(stall_count), 32'd4);
        tick();
        set_issue(1'b0, 1'b0, '0, '0);
        pulse_reset();

        // async reset mid-countdown
        set_issue(1'b1, 1'b1, 5'd9, 3'd5);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        #1 chk("ar_stall_before", 32'(stall), 32'd1);
        tick();
        tick();
        chk("ar_count_before", 32'(stall_count), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_full", 32'(sb_full), 32'd0);
        chk("ar_count", 32'(stall_count), 32'd0);
        #1 rst = 1'b0;
        #1 chk("ar_dep_free", 32'(stall), 32'd0);
        tick();
        chk("ar_dep_accepted", 32'(stall_count), 32'd0);
        set_issue(1'b0, 1'b0, '0, '0);
        id_rs = '0; id_rs_used = '0;
        pulse_reset();

        // saturation
        for (int r = 0; r < 3; r++) begin
            set_issue(1'b1, 1'b1, 5'd9, 3'd7);
            id_rs = '0; id_rs_used = '0;
            tick();
            set_issue(1'b1, 1'b0, 5'd0, 3'd0);
            id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
            count_stalls(n);
            chk("sat_round_stalls", 32'(n), 32'd7);
            chk("sat_count", 32'(stall_count), (r == 0) ? 32'd7 : (r == 1) ? 32'd14 : 32'd15);
            tick();
        end
        set_issue(1'b0, 1'b0, '0, '0);
        id_rs = '0; id_rs_used = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
